xalu_nibble_seq: RTL and testbench
==================================

Name: xalu_nibble_seq

Overview:
- Multi-nibble sequencer that runs wide operations through the 4-bit xalu slice, one nibble per clock.
- Upstream side: latches wide operands, function code, complement mode and carry-in, then drives the slice's A/B/F/ci_left/ci_right/COM inputs.
- Downstream side: captures the slice's d, co_left, co_right, ZERO and EQU outputs; assembles the wide result and flags; presents them with a done pulse.
- Lets one slice instance act as an N×4-bit ALU.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operation (data width = 4*NIBBLES); legal range 2..8

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only in IDLE or DONE
op  input  3  function code, same encoding as slice F: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 PASSA, 5 PASSB, 6 SHR, 7 SHL
com  input  1  complement-output mode, forwarded to slice COM
cin  input  1  carry / shift-in bit for the first nibble
opa  input  4*NIBBLES  operand A
opb  input  4*NIBBLES  operand B
alu_a  output  4  current nibble of A to slice
alu_b  output  4  current nibble of B to slice
alu_f  output  3  function code to slice
alu_com  output  1  COM to slice
alu_ci_right  output  1  right carry-in to slice
alu_ci_left  output  1  left carry-in to slice
alu_d  input  4  slice data output
alu_co_left  input  1  slice left carry-out
alu_co_right  input  1  slice right carry-out
alu_zero  input  1  slice +zero flag
alu_equ  input  1  slice A=B flag
busy  output  1  operation in progress
done  output  1  one-cycle pulse, result valid
result  output  4*NIBBLES  assembled result, held until next accepted start
cout  output  1  final chained carry
zero  output  1  all result nibbles zero (post-COM)
equ  output  1  opa == opb

Behaviour:
- Reset (async, rst_n low): state IDLE. All outputs 0: busy, done, result, cout, zero, equ, alu_a, alu_b, alu_f, alu_com, alu_ci_right, alu_ci_left. Reset mid-operation aborts with no done pulse; partial results are discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE to RUN when start=1 at a clock edge:
  - latch opa, opb, op, com.
  - carry register <= cin.
  - zero_acc <= 1, equ_acc <= 1.
  - nibble index <= NIBBLES-1 if op==6 (SHR), else 0.
- start in RUN is ignored; no queuing.
- DONE to IDLE when start=0.
- RUN, one nibble per cycle, index k:
  - alu_a = opa_reg[4k+3:4k], alu_b = opb_reg[4k+3:4k], alu_f = op_reg, alu_com = com_reg.
  - Ops 0–5 and 7 (LSB-first chain): alu_ci_right = carry, alu_ci_left = 0. At the edge, carry <= alu_co_left and index increments.
  - Op 6, SHR (MSB-first chain): alu_ci_left = carry, alu_ci_right = 0. At the edge, carry <= alu_co_right and index decrements.
  - Every RUN edge: result[4k+3:4k] <= alu_d, zero_acc &= alu_zero, equ_acc &= alu_equ.
  - After the last nibble is captured (index NIBBLES-1 ascending, or 0 descending), go to DONE.
- DONE: done=1 for exactly one cycle; busy=0; cout, zero, equ take their final values; result holds.
- Outside RUN, alu_* outputs are 0. Those are slice ADD inputs, so slice outputs are ignored then.
- busy=1 exactly in RUN.
- Timing:
  - start sampled at edge E0.
  - RUN cycles follow E0, E1 … E(NIBBLES-1).
  - done high in the cycle after edge E(NIBBLES).
  - Start-to-done latency = NIBBLES+1 edges.
  - Back-to-back: start during the DONE cycle begins the next RUN at the next edge; throughput is one op per NIBBLES+1 cycles.
- Flag semantics:
  - cout is the final chained carry: top-nibble co_left for ADD/SHL, nibble-0 co_right for SHR, and 0 for ops 1–5 because the slice drives 0 there.
  - zero reflects COM-adjusted data.
  - equ is independent of op and com.
- Widths: no internal arithmetic; the index counter is ceil(log2(NIBBLES)) bits and never wraps past its range.

Test Plan:
- ADD, NIBBLES=4, opa=0x00FF, opb=0x0001, cin=0 -> result 0x0100, cout=0, zero=0, equ=0; busy high 4 cycles; done pulse in cycle 5 after start.
- ADD, opa=0xFFFF, opb=0x0001, cin=0 -> result 0x0000, cout=1, zero=1; repeat with com=1 -> result 0xFFFF, zero=0, cout=1.
- SHL, opa=0x8001, cin=1 -> result 0x0003, cout=1; SHR, opa=0x8001, cin=0 -> result 0x4000, cout=1; confirm alu_a steps nibble 3,2,1,0 for SHR.
- XOR, opa=opb=0x1234 -> result 0x0000, zero=1, equ=1, cout=0; PASSB, opb=0xBEEF -> result 0xBEEF, equ=0.
- start pulsed again during RUN -> ignored, a single done pulse; start held high through DONE -> second op begins immediately, done pulses again NIBBLES+1 edges later.
- rst_n asserted in second RUN cycle -> busy, done, result and all alu_* go 0 asynchronously; no done pulse; next start runs normally.

Source files
------------

// File: rtl/xalu_nibble_seq_if.sv
// Connection bundle between the nibble sequencer and one 4-bit xalu slice.
// The master drives operand nibbles, function and carry-ins.
// The slave (the slice) returns data, carry-outs and flags.
interface xalu_nibble_seq_if;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [2:0] alu_f;
   logic       alu_com;
   logic       alu_ci_right;
   logic       alu_ci_left;
   logic [3:0] alu_d;
   logic       alu_co_left;
   logic       alu_co_right;
   logic       alu_zero;
   logic       alu_equ;

   modport master (
      output alu_a, alu_b, alu_f, alu_com, alu_ci_right, alu_ci_left,
      input  alu_d, alu_co_left, alu_co_right, alu_zero, alu_equ
   );

   modport slave (
      input  alu_a, alu_b, alu_f, alu_com, alu_ci_right, alu_ci_left,
      output alu_d, alu_co_left, alu_co_right, alu_zero, alu_equ
   );
endinterface

// File: rtl/xalu_nibble_seq.sv
// Multi-nibble sequencer: runs a 4*NIBBLES-bit operation through a single
// 4-bit xalu slice, one nibble per clock, chaining the carry between nibbles.
// SHR walks MSB-first (carry enters on the left); every other op walks LSB-first.
// NIBBLES is intended to lie in 2..8.
module xalu_nibble_seq #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [2:0]             op,
   input  logic                   com,
   input  logic                   cin,
   input  logic [4*NIBBLES-1:0]   opa,
   input  logic [4*NIBBLES-1:0]   opb,
   xalu_nibble_seq_if.master      alu,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   result,
   output logic                   cout,
   output logic                   zero,
   output logic                   equ
);

   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = $clog2(NIBBLES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);
   localparam logic [2:0]       OP_SHR   = 3'd6;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q;
   logic [W-1:0]     opa_q;
   logic [W-1:0]     opb_q;
   logic [2:0]       op_q;
   logic [IDX_W-1:0] idx_q;
   logic             zacc_q;
   logic             eacc_q;
   logic [3:0]       alu_a_q;
   logic [3:0]       alu_b_q;
   logic [2:0]       alu_f_q;
   logic             alu_com_q;
   logic             ci_right_q;
   logic             ci_left_q;
   logic             busy_q;
   logic             done_q;
   logic [W-1:0]     result_q;
   logic             cout_q;
   logic             zero_q;
   logic             equ_q;

   logic             shr_new;
   logic             shr_run;
   logic [IDX_W-1:0] idx_first_d;
   logic [IDX_W-1:0] idx_d;
   logic             last_nib;

   // Nibble walk direction and the next/first index to present to the slice.
   always_comb begin
      shr_new     = (op == OP_SHR);
      shr_run     = (op_q == OP_SHR);
      idx_first_d = shr_new ? IDX_LAST : '0;
      idx_d       = shr_run ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
      last_nib    = shr_run ? (idx_q == '0) : (idx_q == IDX_LAST);
   end

   // Sequencer FSM; slice inputs are registered so they are 0 outside RUN.
   // The ci_right/ci_left registers double as the inter-nibble carry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         opa_q      <= '0;
         opb_q      <= '0;
         op_q       <= '0;
         idx_q      <= '0;
         zacc_q     <= 1'b0;
         eacc_q     <= 1'b0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_f_q    <= '0;
         alu_com_q  <= 1'b0;
         ci_right_q <= 1'b0;
         ci_left_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= '0;
         cout_q     <= 1'b0;
         zero_q     <= 1'b0;
         equ_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q    <= S_RUN;
                  opa_q      <= opa;
                  opb_q      <= opb;
                  op_q       <= op;
                  idx_q      <= idx_first_d;
                  zacc_q     <= 1'b1;
                  eacc_q     <= 1'b1;
                  alu_a_q    <= opa[{idx_first_d, 2'b00} +: 4];
                  alu_b_q    <= opb[{idx_first_d, 2'b00} +: 4];
                  alu_f_q    <= op;
                  alu_com_q  <= com;
                  ci_right_q <= shr_new ? 1'b0 : cin;
                  ci_left_q  <= shr_new ? cin : 1'b0;
                  busy_q     <= 1'b1;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_RUN: begin
               result_q[{idx_q, 2'b00} +: 4] <= alu.alu_d;
               if (last_nib) begin
                  state_q    <= S_DONE;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  cout_q     <= shr_run ? alu.alu_co_right : alu.alu_co_left;
                  zero_q     <= zacc_q & alu.alu_zero;
                  equ_q      <= eacc_q & alu.alu_equ;
                  alu_a_q    <= '0;
                  alu_b_q    <= '0;
                  alu_f_q    <= '0;
                  alu_com_q  <= 1'b0;
                  ci_right_q <= 1'b0;
                  ci_left_q  <= 1'b0;
               end else begin
                  idx_q      <= idx_d;
                  zacc_q     <= zacc_q & alu.alu_zero;
                  eacc_q     <= eacc_q & alu.alu_equ;
                  alu_a_q    <= opa_q[{idx_d, 2'b00} +: 4];
                  alu_b_q    <= opb_q[{idx_d, 2'b00} +: 4];
                  ci_right_q <= shr_run ? 1'b0 : alu.alu_co_left;
                  ci_left_q  <= shr_run ? alu.alu_co_right : 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign alu.alu_a        = alu_a_q;
   assign alu.alu_b        = alu_b_q;
   assign alu.alu_f        = alu_f_q;
   assign alu.alu_com      = alu_com_q;
   assign alu.alu_ci_right = ci_right_q;
   assign alu.alu_ci_left  = ci_left_q;

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign cout   = cout_q;
   assign zero   = zero_q;
   assign equ    = equ_q;

endmodule

// File: tb/tb_xalu_nibble_seq.sv
// Bench for xalu_nibble_seq with NIBBLES=4, including a behavioural 4-bit
// xalu slice hooked to the sequencer's slice bus.
module tb_xalu_nibble_seq;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [2:0]    op;
   logic          com;
   logic          cin;
   logic [15:0]   opa;
   logic [15:0]   opb;
   logic          busy;
   logic          done;
   logic [15:0]   result;
   logic          cout;
   logic          zero;
   logic          equ;

   xalu_nibble_seq_if bus ();

   xalu_nibble_seq #(.NIBBLES(N)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .com    (com),
      .cin    (cin),
      .opa    (opa),
      .opb    (opb),
      .alu    (bus),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
      .zero   (zero),
      .equ    (equ)
   );

   always #5 clk = ~clk;

   // Behavioural 4-bit slice
   logic [4:0] s_sum;
   logic [3:0] s_raw;
   logic       s_col;
   logic       s_cor;
   always_comb begin
      s_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {4'b0, bus.alu_ci_right};
      s_raw = 4'h0;
      s_col = 1'b0;
      s_cor = 1'b0;
      case (bus.alu_f)
         3'd0: begin s_raw = s_sum[3:0]; s_col = s_sum[4]; end
         3'd1: s_raw = bus.alu_a & bus.alu_b;
         3'd2: s_raw = bus.alu_a | bus.alu_b;
         3'd3: s_raw = bus.alu_a ^ bus.alu_b;
         3'd4: s_raw = bus.alu_a;
         3'd5: s_raw = bus.alu_b;
         3'd6: begin s_raw = {bus.alu_ci_left, bus.alu_a[3:1]}; s_cor = bus.alu_a[0]; end
         default: begin s_raw = {bus.alu_a[2:0], bus.alu_ci_right}; s_col = bus.alu_a[3]; end
      endcase
      bus.alu_d        = bus.alu_com ? ~s_raw : s_raw;
      bus.alu_co_left  = s_col;
      bus.alu_co_right = s_cor;
      bus.alu_zero     = ((bus.alu_com ? ~s_raw : s_raw) == 4'h0);
      bus.alu_equ      = (bus.alu_a == bus.alu_b);
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Captured per operation
   logic [15:0] r_res;
   logic        r_cout;
   logic        r_zero;
   logic        r_equ;
   int          busy_cnt;
   int          done_cyc;
   int          done_cnt;
   logic [3:0]  seq_a [0:7];

   // Launch one op and observe 12 cycles; mid_start pulses start during RUN.
   task automatic run_op(input logic [2:0] o, input logic c, input logic ci,
                         input logic [15:0] a, input logic [15:0] b, input logic mid_start);
      @(negedge clk);
      op = o; com = c; cin = ci; opa = a; opb = b; start = 1'b1;
      @(posedge clk);
      busy_cnt = 0; done_cyc = 0; done_cnt = 0;
      r_res = 16'h0; r_cout = 1'b0; r_zero = 1'b0; r_equ = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
         if (mid_start && i == 2) start = 1'b1;
         if (mid_start && i == 3) start = 1'b0;
         if (busy) begin
            if (busy_cnt < 8) seq_a[busy_cnt] = bus.alu_a;
            busy_cnt++;
         end
         if (done) begin
            done_cnt++;
            if (done_cyc == 0) begin
               done_cyc = i;
               r_res = result; r_cout = cout; r_zero = zero; r_equ = equ;
            end
         end
      end
   endtask

   int          d1;
   int          d2;
   logic [15:0] res1;
   logic [15:0] res2;
   logic        seen_done;
   logic        b2b_busy;

   initial begin
      rst_n = 1'b0; start = 1'b0; op = 3'd0; com = 1'b0; cin = 1'b0;
      opa = 16'h0; opb = 16'h0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", {cout, zero, equ}, 0);
      chk("rst_alu_out", {bus.alu_a, bus.alu_b, bus.alu_f, bus.alu_com,
                          bus.alu_ci_right, bus.alu_ci_left}, 0);
      rst_n = 1'b1;

      // ADD 0x00FF + 0x0001
      run_op(3'd0, 1'b0, 1'b0, 16'h00FF, 16'h0001, 1'b0);
      chk("add1_res", r_res, 16'h0100);
      chk("add1_flags", {r_cout, r_zero, r_equ}, 3'b000);
      chk("add1_busy_cycles", busy_cnt, 4);
      chk("add1_done_cycle", done_cyc, 5);
      chk("add1_done_count", done_cnt, 1);
      chk("add1_alu_a_seq", {seq_a[0], seq_a[1], seq_a[2], seq_a[3]}, 16'hFF00);

      // ADD 0xFFFF + 0x0001, plain and complemented
      run_op(3'd0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
      chk("add2_res", r_res, 16'h0000);
      chk("add2_cout_zero", {r_cout, r_zero}, 2'b11);
      run_op(3'd0, 1'b1, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
      chk("add2com_res", r_res, 16'hFFFF);
      chk("add2com_cout_zero", {r_cout, r_zero}, 2'b10);

      // SHL 0x8001, cin=1
      run_op(3'd7, 1'b0, 1'b1, 16'h8001, 16'h0000, 1'b0);
      chk("shl_res", r_res, 16'h0003);
      chk("shl_cout", r_cout, 1);

      // SHR 0x8001, cin=0: MSB nibble first
      run_op(3'd6, 1'b0, 1'b0, 16'h8001, 16'h0000, 1'b0);
      chk("shr_res", r_res, 16'h4000);
      chk("shr_cout", r_cout, 1);
      chk("shr_alu_a_seq", {seq_a[0], seq_a[1], seq_a[2], seq_a[3]}, 16'h8001);
      chk("shr_done_cycle", done_cyc, 5);

      // XOR equal operands
      run_op(3'd3, 1'b0, 1'b0, 16'h1234, 16'h1234, 1'b0);
      chk("xor_res", r_res, 16'h0000);
      chk("xor_flags", {r_cout, r_zero, r_equ}, 3'b011);

      // PASSB
      run_op(3'd5, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 1'b0);
      chk("passb_res", r_res, 16'hBEEF);
      chk("passb_flags", {r_cout, r_zero, r_equ}, 3'b000);

      // Start pulsed during RUN is ignored
      run_op(3'd2, 1'b0, 1'b0, 16'h0F0F, 16'hF000, 1'b1);
      chk("midstart_res", r_res, 16'hFF0F);
      chk("midstart_done_count", done_cnt, 1);
      chk("midstart_done_cycle", done_cyc, 5);

      // Start held high through DONE: back-to-back ops
      @(negedge clk);
      op = 3'd0; com = 1'b0; cin = 1'b0; opa = 16'h00FF; opb = 16'h0001; start = 1'b1;
      @(posedge clk);
      d1 = 0; d2 = 0; res1 = 16'h0; res2 = 16'h0; b2b_busy = 1'b0;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         if (i == 5) begin op = 3'd3; opa = 16'hF0F0; opb = 16'h0FF0; end
         if (i == 6) begin start = 1'b0; b2b_busy = busy; end
         if (done) begin
            if (d1 == 0) begin d1 = i; res1 = result; end
            else if (d2 == 0) begin d2 = i; res2 = result; end
         end
      end
      chk("b2b_first_done", d1, 5);
      chk("b2b_first_res", res1, 16'h0100);
      chk("b2b_restart_busy", b2b_busy, 1);
      chk("b2b_second_done", d2, 10);
      chk("b2b_second_res", res2, 16'hFF00);

      // Reset asserted in the second RUN cycle
      @(negedge clk);
      op = 3'd2; com = 1'b1; cin = 1'b1; opa = 16'hABCD; opb = 16'h1234; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("arst_pre_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_result", result, 0);
      chk("arst_alu_out", {bus.alu_a, bus.alu_b, bus.alu_f, bus.alu_com,
                           bus.alu_ci_right, bus.alu_ci_left}, 0);
      seen_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 2) rst_n = 1'b1;
         if (done) seen_done = 1'b1;
      end
      chk("arst_no_done", seen_done, 0);

      // Normal op after reset
      run_op(3'd0, 1'b0, 1'b0, 16'h1111, 16'h2222, 1'b0);
      chk("post_rst_res", r_res, 16'h3333);
      chk("post_rst_done_count", done_cnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
